// File: rtl/tt_param_counter_pkg.sv
// Shared types and bit-index constants for the parametrised counter tile.
package counter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  localparam int unsigned STAT_TC   = 0;
  localparam int unsigned STAT_OVF  = 1;
  localparam int unsigned STAT_BUSY = 2;
  localparam int unsigned STAT_ZERO = 3;

  localparam int unsigned UI_CNT_EN = 0;
  localparam int unsigned UI_DIR    = 1;
  localparam int unsigned UI_LOAD   = 2;
  localparam int unsigned UI_MODE   = 3;
  localparam int unsigned UI_SEL_LO = 4;
  localparam int unsigned UI_SEL_HI = 5;
  localparam int unsigned UI_CLEAR  = 6;
  localparam int unsigned UI_SNAP   = 7;

  localparam logic [7:0] UIO_OE_IDLE = 8'h0F;
  localparam logic [7:0] UIO_OE_LOAD = 8'h00;

endpackage

// File: rtl/tt_param_counter_if.sv
// Tile pin bundle; master drives the pads, slave is the counter.
interface tt_param_counter_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_param_counter_edge_rise.sv
// Single-stage rising-edge detector; keeps sampling regardless of ena.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= d;
  end

  assign pulse = d & ~r_prev;
endmodule

// File: rtl/tt_param_counter.sv
// Parametrised up/down counter tile with byte-serial load and byte-muxed read.
// Optional build macro: COUNTER_SNAPSHOT_EN (read port serves a snapshot register).
module tt_param_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  tt_param_counter_if.slave bus
);
  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [WIDTH-1:0] MAX = '1;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, r_shift, w_load_val, w_src;
  logic [IDX_W-1:0] r_idx;
  logic             r_ovf, r_tc;
  logic             w_load_pulse, w_busy, w_up, w_sat;
  logic [7:0]       w_oe, w_uo, w_stat;

  assign w_up  = bus.ui_in[UI_DIR];
  assign w_sat = bus.ui_in[UI_MODE];

  edge_rise u_load_edge (.clk(clk), .rst_n(rst_n), .d(bus.ui_in[UI_LOAD]), .pulse(w_load_pulse));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Clear wins over everything; a load edge during LOAD is ignored.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.ena) begin
      if (bus.ui_in[UI_CLEAR]) begin
        w_state_nxt = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: if (w_load_pulse) w_state_nxt = ST_LOAD;
          ST_LOAD: if (r_idx == LAST_IDX) w_state_nxt = ST_IDLE;
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    w_busy = (r_state == ST_LOAD);
    w_oe   = w_busy ? UIO_OE_LOAD : UIO_OE_IDLE;
  end

  // Current shift contents with the incoming byte dropped into its slot.
  always_comb begin
    w_load_val = r_shift;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (r_idx == IDX_W'(b)) w_load_val[b*8 +: 8] = bus.uio_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (bus.ena) begin
        if (bus.ui_in[UI_CLEAR]) begin
          r_count <= '0;
          r_shift <= '0;
          r_idx   <= '0;
          r_ovf   <= 1'b0;
        end else if (r_state == ST_LOAD) begin
          r_shift <= w_load_val;
          if (r_idx == LAST_IDX) begin
            r_count <= w_load_val;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end else if (!w_load_pulse && bus.ui_in[UI_CNT_EN]) begin
          if (w_up) begin
            if (r_count == MAX) begin
              r_ovf <= 1'b1;
              if (!w_sat) begin
                r_count <= '0;
                r_tc    <= 1'b1;
              end
            end else begin
              r_count <= r_count + WIDTH'(1);
              r_tc    <= w_sat && (r_count == MAX - WIDTH'(1));
            end
          end else begin
            if (r_count == '0) begin
              r_ovf <= 1'b1;
              if (!w_sat) begin
                r_count <= MAX;
                r_tc    <= 1'b1;
              end
            end else begin
              r_count <= r_count - WIDTH'(1);
              r_tc    <= w_sat && (r_count == WIDTH'(1));
            end
          end
        end
      end
    end
  end

`ifdef COUNTER_SNAPSHOT_EN
  logic             w_snap_pulse;
  logic [WIDTH-1:0] r_snap;

  edge_rise u_snap_edge (.clk(clk), .rst_n(rst_n), .d(bus.ui_in[UI_SNAP]), .pulse(w_snap_pulse));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_snap <= '0;
    else if (bus.ena && w_snap_pulse)  r_snap <= r_count;
  end

  assign w_src = r_snap;
`else
  logic w_unused_snap;
  assign w_unused_snap = bus.ui_in[UI_SNAP];
  assign w_src         = r_count;
`endif

  // Byte-select read mux; selects past the counter width read zero.
  always_comb begin
    w_uo = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (bus.ui_in[UI_SEL_HI:UI_SEL_LO] == 2'(b)) w_uo = w_src[b*8 +: 8];
    end
  end

  always_comb begin
    w_stat            = '0;
    w_stat[STAT_TC]   = r_tc;
    w_stat[STAT_OVF]  = r_ovf;
    w_stat[STAT_BUSY] = w_busy;
    w_stat[STAT_ZERO] = (r_count == '0);
  end

  assign bus.uo_out  = w_uo;
  assign bus.uio_out = w_stat;
  assign bus.uio_oe  = w_oe;

endmodule

// File: tb/tb_tt_param_counter.sv
// Randomised and directed bench for tt_param_counter against a behavioural model.
module tb_tt_param_counter;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned BYTES = WIDTH / 8;
  localparam longint unsigned MAXV = (64'd1 << WIDTH) - 64'd1;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  tt_param_counter_if bus ();
  tt_param_counter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  longint unsigned m_count, m_snap;
  bit              m_ovf, m_tc, m_loading, m_prev_load, m_prev_snap;
  byte unsigned    m_q[$];

  function automatic void model_reset();
    m_count = 0; m_snap = 0; m_ovf = 0; m_tc = 0;
    m_loading = 0; m_prev_load = 0; m_prev_snap = 0;
    m_q.delete();
  endfunction

  // Next-cycle behaviour from the current pin values.
  function automatic void model_step();
    bit le, se, nt;
    logic [7:0] ui;
    ui = bus.ui_in;
    le = ui[2] && !m_prev_load;
    se = ui[7] && !m_prev_snap;
    m_prev_load = ui[2];
    m_prev_snap = ui[7];
    nt = 0;
    if (bus.ena) begin
      if (se) m_snap = m_count;
      if (ui[6]) begin
        m_count = 0; m_ovf = 0; m_loading = 0; m_q.delete();
      end else if (m_loading) begin
        m_q.push_back(bus.uio_in);
        if (m_q.size() == BYTES) begin
          m_count = 0;
          foreach (m_q[i]) m_count |= 64'(m_q[i]) << (8 * i);
          m_ovf = 0; m_loading = 0; m_q.delete();
        end
      end else if (le) begin
        m_loading = 1;
      end else if (ui[0]) begin
        if (ui[1]) begin
          if (ui[3]) begin
            if (m_count == MAXV) m_ovf = 1;
            else begin m_count++; nt = (m_count == MAXV); end
          end else begin
            m_count = (m_count + 1) % (MAXV + 1);
            if (m_count == 0) begin nt = 1; m_ovf = 1; end
          end
        end else begin
          if (ui[3]) begin
            if (m_count == 0) m_ovf = 1;
            else begin m_count--; nt = (m_count == 0); end
          end else if (m_count == 0) begin
            m_count = MAXV; nt = 1; m_ovf = 1;
          end else m_count--;
        end
      end
    end
    m_tc = nt;
  endfunction

  function automatic logic [7:0] exp_uo();
    longint unsigned src;
    int sel;
    sel = int'(bus.ui_in[5:4]);
`ifdef COUNTER_SNAPSHOT_EN
    src = m_snap;
`else
    src = m_count;
`endif
    if (sel >= int'(BYTES)) return 8'h00;
    return 8'(src >> (8 * sel));
  endfunction

  function automatic logic [7:0] exp_uio();
    return {4'h0, (m_count == 0), m_loading, m_ovf, m_tc};
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.ui_in = 8'h04; cycle();
    bus.ui_in = 8'h00;
    bus.uio_in = v[7:0];  cycle();
    bus.uio_in = v[15:8]; cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.ena = 1'b0; bus.ui_in = 8'h00; bus.uio_in = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.uo_out  !== 8'h00) begin bad++; $display("FAIL reset_uo got=%h exp=%h", bus.uo_out, 8'h00); end
    total++; if (bus.uio_out !== 8'h08) begin bad++; $display("FAIL reset_uio got=%h exp=%h", bus.uio_out, 8'h08); end
    total++; if (bus.uio_oe  !== 8'h0F) begin bad++; $display("FAIL reset_oe got=%h exp=%h", bus.uio_oe, 8'h0F); end
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    bus.ena = 1'b1; bus.ui_in = 8'h03;
    repeat (3) cycle();
    total++; if (bus.uo_out !== 8'h03) begin bad++; $display("FAIL count_up_byte0 got=%h exp=%h", bus.uo_out, 8'h03); end
    total++; if (bus.uio_out !== 8'h00) begin bad++; $display("FAIL count_up_status got=%h exp=%h", bus.uio_out, 8'h00); end
  endtask

  task automatic test_load_wrap();
    bus.ui_in = 8'h04; cycle();
    total++; if (bus.uio_oe !== 8'h00) begin bad++; $display("FAIL load_oe got=%h exp=%h", bus.uio_oe, 8'h00); end
    total++; if (bus.uio_out !== 8'h04) begin bad++; $display("FAIL load_busy1 got=%h exp=%h", bus.uio_out, 8'h04); end
    bus.ui_in = 8'h00; bus.uio_in = 8'hFE; cycle();
    total++; if (bus.uio_out !== 8'h04) begin bad++; $display("FAIL load_busy2 got=%h exp=%h", bus.uio_out, 8'h04); end
    bus.uio_in = 8'hFF; cycle();
    total++; if (bus.uo_out !== 8'hFE) begin bad++; $display("FAIL load_byte0 got=%h exp=%h", bus.uo_out, 8'hFE); end
    total++; if (bus.uio_oe !== 8'h0F) begin bad++; $display("FAIL load_done_oe got=%h exp=%h", bus.uio_oe, 8'h0F); end
    bus.ui_in = 8'h10; #1;
    total++; if (bus.uo_out !== 8'hFF) begin bad++; $display("FAIL load_byte1 got=%h exp=%h", bus.uo_out, 8'hFF); end
    bus.ui_in = 8'h03; cycle();
    total++; if (bus.uo_out !== 8'hFF || bus.uio_out !== 8'h00) begin bad++; $display("FAIL wrap_ffff got=%h/%h exp=ff/00", bus.uo_out, bus.uio_out); end
    cycle();
    total++; if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h0B) begin bad++; $display("FAIL wrap_zero got=%h/%h exp=00/0b", bus.uo_out, bus.uio_out); end
    bus.ui_in = 8'h00; cycle();
    total++; if (bus.uio_out !== 8'h0A) begin bad++; $display("FAIL wrap_tc_drop got=%h exp=%h", bus.uio_out, 8'h0A); end
  endtask

  task automatic test_saturate();
    do_load(16'hFFFE);
    total++; if (bus.uio_out !== 8'h00) begin bad++; $display("FAIL sat_load_ovf_clr got=%h exp=%h", bus.uio_out, 8'h00); end
    bus.ui_in = 8'h0B; cycle();
    total++; if (bus.uo_out !== 8'hFF || bus.uio_out !== 8'h01) begin bad++; $display("FAIL sat_up_first got=%h/%h exp=ff/01", bus.uo_out, bus.uio_out); end
    repeat (3) cycle();
    total++; if (bus.uo_out !== 8'hFF || bus.uio_out !== 8'h02) begin bad++; $display("FAIL sat_up_held got=%h/%h exp=ff/02", bus.uo_out, bus.uio_out); end
    bus.ui_in = 8'h10; #1;
    total++; if (bus.uo_out !== 8'hFF) begin bad++; $display("FAIL sat_up_hi got=%h exp=%h", bus.uo_out, 8'hFF); end
    do_load(16'h0001);
    bus.ui_in = 8'h09; cycle();
    total++; if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h09) begin bad++; $display("FAIL sat_dn_first got=%h/%h exp=00/09", bus.uo_out, bus.uio_out); end
    cycle();
    total++; if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h0A) begin bad++; $display("FAIL sat_dn_held got=%h/%h exp=00/0a", bus.uo_out, bus.uio_out); end
  endtask

  task automatic test_clear_abort();
    bus.ui_in = 8'h04; cycle();
    bus.ui_in = 8'h00; bus.uio_in = 8'hAA; cycle();
    bus.ui_in = 8'h40; bus.uio_in = 8'hBB; cycle();
    total++; if (bus.uio_oe !== 8'h0F) begin bad++; $display("FAIL clr_oe got=%h exp=%h", bus.uio_oe, 8'h0F); end
    total++; if (bus.uio_out !== 8'h08 || bus.uo_out !== 8'h00) begin bad++; $display("FAIL clr_state got=%h/%h exp=08/00", bus.uio_out, bus.uo_out); end
    bus.ui_in = 8'h00; cycle();
    total++; if (bus.uo_out !== 8'h00 || bus.uio_oe !== 8'h0F) begin bad++; $display("FAIL clr_no_load got=%h/%h exp=00/0f", bus.uo_out, bus.uio_oe); end
  endtask

  task automatic test_sel_freeze();
    do_load(16'h5A3C);
    bus.ui_in = 8'h20; #1;
    total++; if (bus.uo_out !== 8'h00) begin bad++; $display("FAIL sel2 got=%h exp=%h", bus.uo_out, 8'h00); end
    bus.ui_in = 8'h30; #1;
    total++; if (bus.uo_out !== 8'h00) begin bad++; $display("FAIL sel3 got=%h exp=%h", bus.uo_out, 8'h00); end
    bus.ena = 1'b0; bus.ui_in = 8'h03;
    repeat (3) cycle();
    total++; if (bus.uo_out !== 8'h3C || bus.uio_out !== 8'h00) begin bad++; $display("FAIL freeze got=%h/%h exp=3c/00", bus.uo_out, bus.uio_out); end
    bus.ena = 1'b1; bus.ui_in = 8'h00; cycle();
  endtask

  task automatic test_snapshot();
    logic [7:0] e0, e1;
`ifdef COUNTER_SNAPSHOT_EN
    e0 = 8'hFF; e1 = 8'h12;
`else
    e0 = 8'h02; e1 = 8'h13;
`endif
    do_load(16'h12FE);
    bus.ui_in = 8'h03; cycle();
    bus.ui_in = 8'h83; cycle();
    bus.ui_in = 8'h03; repeat (2) cycle();
    bus.ui_in = 8'h00; #1;
    total++; if (bus.uo_out !== e0) begin bad++; $display("FAIL snap_byte0 got=%h exp=%h", bus.uo_out, e0); end
    bus.ui_in = 8'h10; #1;
    total++; if (bus.uo_out !== e1) begin bad++; $display("FAIL snap_byte1 got=%h exp=%h", bus.uo_out, e1); end
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int i = 0; i < 400; i++) begin
      bus.ena = ($urandom_range(0, 7) != 0);
      v = 8'($urandom);
      v[6] = ($urandom_range(0, 15) == 0);
      v[2] = ($urandom_range(0, 3) == 0);
      bus.ui_in  = v;
      bus.uio_in = 8'($urandom);
      cycle();
      total++; if (bus.uo_out  !== exp_uo())  begin bad++; $display("FAIL rnd_uo i=%0d got=%h exp=%h", i, bus.uo_out, exp_uo()); end
      total++; if (bus.uio_out !== exp_uio()) begin bad++; $display("FAIL rnd_uio i=%0d got=%h exp=%h", i, bus.uio_out, exp_uio()); end
      total++; if (bus.uio_oe  !== (m_loading ? 8'h00 : 8'h0F)) begin bad++; $display("FAIL rnd_oe i=%0d got=%h exp=%h", i, bus.uio_oe, (m_loading ? 8'h00 : 8'h0F)); end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_load_wrap();
    test_saturate();
    test_clear_abort();
    test_sel_freeze();
    test_snapshot();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tt_param_counter.md
# tt_param_counter

Parametrised up/down counter tile on the standard tile pinout; successor to the fixed 8-bit counting/adder tile. Adds selectable width, direction, a wrap or saturate boundary mode, byte-serial parallel load through the bidirectional pins, terminal-count and sticky-overflow status, and a byte-multiplexed read port. It sits directly behind the tile wrapper pins: no other logic lies between the pads and this block.

## Interface
- WIDTH, 16: counter width in bits; 8, 16, 24 or 32 only (a multiple of 8); BYTES = WIDTH/8.
- clk  in  1  tile clock; all state is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  design selected; 0 freezes counting and the load FSM.
- ui_in  in  8  [0] count enable, [1] dir (1 up, 0 down), [2] load start (rising edge), [3] mode (1 saturate, 0 wrap), [5:4] read byte select, [6] synchronous clear, [7] snapshot strobe (rising edge).
- uo_out  out  8  selected byte of the read source.
- uio_in  in  8  load data byte, LSB byte first.
- uio_out  out  8  [0] tc pulse, [1] overflow sticky, [2] load busy, [3] count==0, [7:4] 0.
- uio_oe  out  8  8'h0F in IDLE, 8'h00 in LOAD.

## Operation
- FSM states: IDLE and LOAD. IDLE→LOAD on a rising edge of ui_in[2] while ena=1. LOAD captures uio_in for BYTES cycles into a shift register, byte 0 first. After the last byte, count = assembled value, overflow is cleared, and the FSM returns to IDLE.
- Counting happens only in IDLE with ena=1 and ui_in[0]=1: count ±1 each cycle.
- Wrap mode: max+1→0 and 0−1→max. Each wrap pulses tc and sets overflow.
- Saturate mode: count holds at max (counting up) or 0 (counting down). tc pulses on the step that first reaches the boundary. Each blocked step sets overflow.
- Priority when events coincide: clear > load start / load in progress > count.
  - Clear sets count=0, overflow=0, tc=0 and aborts LOAD to IDLE.
- A load edge seen during LOAD is ignored. dir and mode are sampled every cycle with no hold requirement.
- Read port: uo_out = byte ui_in[5:4] of the read source. A select value ≥ BYTES reads 8'h00.
- ena=0 holds all state, including the LOAD byte index. Edge detectors keep sampling so that no false edges appear when ena returns.
- Reset values: count 0, snapshot 0, state IDLE, overflow 0, tc 0, uo_out 8'h00, uio_out 8'h08 (zero flag set), uio_oe 8'h0F.
- Reset during LOAD discards the partial data.

## Timing
- Count changes one cycle after enable is sampled high. uo_out and the status bits reflect the new count in that same cycle (registered state driving combinational muxes).
- tc is registered and high for exactly one cycle, aligned with the cycle in which count first shows the boundary/wrapped value.
- Load: the edge on ui_in[2] is sampled at cycle N. Data bytes are sampled at N+1 … N+BYTES. Count shows the loaded value at N+BYTES+1. busy (uio_out[2]) is high N+1 … N+BYTES.
- Edge detect: one register stage per input, so an edge occurs where the current sample is 1 and the previous sample is 0.

## Configuration
- COUNTER_SNAPSHOT_EN defined: a rising edge on ui_in[7] copies count into a WIDTH-bit snapshot register one cycle later. The read port reads the snapshot, which gives coherent multi-byte reads.
- Not defined: the read port reads the live count, ui_in[7] is ignored, and there is no snapshot register.

## Structure
- Package counter_pkg holds:
  - the state enum (ST_IDLE, ST_LOAD);
  - the status bit index constants (STAT_TC, STAT_OVF, STAT_BUSY, STAT_ZERO);
  - the UI bit index constants;
  - the UIO_OE_IDLE and UIO_OE_LOAD constants.
- One sub-module: edge_rise (clk, rst_n, d → pulse), instantiated for load start and snapshot.

## Test plan
- Reset, WIDTH=16: uo_out=00, uio_out=08, uio_oe=0F. Enable up for 3 cycles → byte 0 reads 03, zero flag clears.
- Load: edge on ui_in[2], then uio_in=FE, FF → busy for 2 cycles, uio_oe=00, count=FFFE. Two up steps in wrap mode → FFFF then 0000, with tc for 1 cycle and overflow=1.
- Saturate: load FFFE, count up 4 cycles → FFFF held, tc once, overflow=1. Down from 0001 → 0000 held, tc once.
- Clear asserted on the second load byte → count 0000, state IDLE, uio_oe=0F, no loaded value appears.
- Byte select 2 or 3 with WIDTH=16 → uo_out=00. ena=0 while enabled → count frozen.
- With COUNTER_SNAPSHOT_EN: count at 12FF, snapshot edge, keep counting → bytes read FF then 12 unchanged. Without the macro → uo_out tracks the live count.
